// File: rtl/clint_trap_ctrl_pkg.sv
// Purpose : shared definitions for the core-local trap sequencer.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: CSR addresses, system-instruction encodings, mcause codes, FSM states.
package clint_trap_ctrl_pkg;

  // CSR addresses touched by the clint write port
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // System instruction encodings (exact 32-bit match)
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // mstatus bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // mcause exception/interrupt codes; interrupt flag lives in the MSB
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;
  localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;

  typedef struct packed {
    logic       irq;
    logic [3:0] code;
  } cause_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_MRET    = 3'd4
  } state_e;

endpackage

// File: rtl/clint_mtimer.sv
// Purpose : free-running 64-bit mtime counter with mtimecmp compare.
// Latency : timer_irq_o is combinational from the registered mtime value.
// Backpr. : none; counts every cycle, wraps modulo 2^64.
// Ports   : clk, rst (sync, active-high), mtimecmp_i[63:0] -> timer_irq_o (level).
module clint_mtimer (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtimecmp_i,
  output logic        timer_irq_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;

  always_comb begin
    mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= 64'd0;
    end else begin
      mtime_q <= mtime_d;
    end
  end

  assign timer_irq_o = (mtime_q >= mtimecmp_i);

endmodule

// File: rtl/clint_trap_ctrl.sv
// Purpose : core-local trap sequencer; detects ecall/ebreak/mret/irq in ID, stalls,
//           writes mepc/mstatus/mcause via the clint CSR port, redirects fetch.
// Latency : trap = detect + 3 write cycles (redirect on the 3rd); mret = detect + 1.
// Backpr. : hold_o stalls the pipeline from detect through the redirect cycle;
//           new requests are ignored until the FSM is back in IDLE.
// Ports   : clk, rst (sync, active-high); inst_i/inst_addr_i from ID; jump_flag_i/
//           jump_addr_i from EX; int_flag_i irq levels; csr_* live CSR values;
//           global_int_en_i = mstatus.MIE; we_o/waddr_o/raddr_o/data_o clint CSR
//           port; hold_o stall; int_assert_o/int_addr_o fetch redirect.
// Config  : CLINT_TIMER_EN adds mtimecmp_i and the clint_mtimer timer interrupt.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int INT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  input  logic             global_int_en_i,
`ifdef CLINT_TIMER_EN
  input  logic [63:0]      mtimecmp_i,
`endif
  output logic             we_o,
  output logic [XLEN-1:0]  waddr_o,
  output logic [XLEN-1:0]  raddr_o,
  output logic [XLEN-1:0]  data_o,
  output logic             hold_o,
  output logic             int_assert_o,
  output logic [XLEN-1:0]  int_addr_o
);

  localparam logic [XLEN-1:0] WADDR_MSTATUS = XLEN'(CSR_MSTATUS);
  localparam logic [XLEN-1:0] WADDR_MEPC    = XLEN'(CSR_MEPC);
  localparam logic [XLEN-1:0] WADDR_MCAUSE  = XLEN'(CSR_MCAUSE);

  state_e          state_q, state_d;
  cause_t          cause_q, cause_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            hold_q, hold_d;
  logic            int_assert_q, int_assert_d;
  logic [XLEN-1:0] int_addr_q, int_addr_d;

  logic            detect;
  logic            timer_irq;
  logic            is_ecall, is_ebreak, is_mret;
  logic            ext_irq, irq_take;
  logic [XLEN-1:0] trap_status, mret_status, cause_word;

`ifdef CLINT_TIMER_EN
  clint_mtimer u_mtimer (
    .clk         (clk),
    .rst         (rst),
    .mtimecmp_i  (mtimecmp_i),
    .timer_irq_o (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign ext_irq   = |int_flag_i;
  assign irq_take  = (ext_irq | timer_irq) & global_int_en_i;

  // Trap entry stacks MIE into MPIE and masks; mret restores MIE and re-arms MPIE.
  // All other mstatus bits pass through untouched.
  always_comb begin
    trap_status                   = csr_mstatus_i;
    trap_status[MSTATUS_MPIE_BIT] = csr_mstatus_i[MSTATUS_MIE_BIT];
    trap_status[MSTATUS_MIE_BIT]  = 1'b0;
    mret_status                   = csr_mstatus_i;
    mret_status[MSTATUS_MIE_BIT]  = csr_mstatus_i[MSTATUS_MPIE_BIT];
    mret_status[MSTATUS_MPIE_BIT] = 1'b1;
  end

  assign cause_word = {cause_q.irq, {(XLEN-5){1'b0}}, cause_q.code};

  // Outputs are registered: the values for a state are computed on the edge
  // that enters it, so the write/redirect of state S appears during S.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    hold_d       = 1'b0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    detect       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rst && (is_ecall || is_ebreak)) begin
          detect  = 1'b1;
          cause_d = '{irq: 1'b0, code: is_ecall ? CAUSE_ECALL : CAUSE_EBREAK};
          state_d = S_MEPC;
          we_d    = 1'b1;
          waddr_d = WADDR_MEPC;
          data_d  = inst_addr_i;
          hold_d  = 1'b1;
        end else if (!rst && is_mret) begin
          detect       = 1'b1;
          state_d      = S_MRET;
          we_d         = 1'b1;
          waddr_d      = WADDR_MSTATUS;
          data_d       = mret_status;
          hold_d       = 1'b1;
          int_assert_d = 1'b1;
          int_addr_d   = csr_mepc_i;
        end else if (!rst && irq_take) begin
          detect  = 1'b1;
          cause_d = '{irq: 1'b1, code: ext_irq ? CAUSE_EXT_IRQ : CAUSE_TIMER_IRQ};
          state_d = S_MEPC;
          we_d    = 1'b1;
          waddr_d = WADDR_MEPC;
          // EX redirect in flight: the instruction in ID is squashed, resume at the target
          data_d  = jump_flag_i ? jump_addr_i : inst_addr_i;
          hold_d  = 1'b1;
        end
      end
      S_MEPC: begin
        state_d = S_MSTATUS;
        we_d    = 1'b1;
        waddr_d = WADDR_MSTATUS;
        data_d  = trap_status;
        hold_d  = 1'b1;
      end
      S_MSTATUS: begin
        state_d      = S_MCAUSE;
        we_d         = 1'b1;
        waddr_d      = WADDR_MCAUSE;
        data_d       = cause_word;
        hold_d       = 1'b1;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_MCAUSE: state_d = S_IDLE;
      S_MRET:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      hold_q       <= 1'b0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign raddr_o      = '0;
  assign data_o       = data_q;
  // Stall starts in the detect cycle itself, before any register has updated
  assign hold_o       = hold_q | detect;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Purpose : directed self-checking bench for clint_trap_ctrl.
// Latency : n/a.
// Backpr. : n/a.
module tb_clint_trap_ctrl;

  localparam int XLEN  = 64;
  localparam int INT_W = 8;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      inst_i;
  logic [XLEN-1:0]  inst_addr_i;
  logic             jump_flag_i;
  logic [XLEN-1:0]  jump_addr_i;
  logic [INT_W-1:0] int_flag_i;
  logic [XLEN-1:0]  csr_mtvec_i;
  logic [XLEN-1:0]  csr_mepc_i;
  logic [XLEN-1:0]  csr_mstatus_i;
  logic             global_int_en_i;
`ifdef CLINT_TIMER_EN
  logic [63:0]      mtimecmp_i;
`endif
  logic             we_o;
  logic [XLEN-1:0]  waddr_o;
  logic [XLEN-1:0]  raddr_o;
  logic [XLEN-1:0]  data_o;
  logic             hold_o;
  logic             int_assert_o;
  logic [XLEN-1:0]  int_addr_o;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clint_trap_ctrl #(.XLEN(XLEN), .INT_W(INT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_flag_i      (int_flag_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .global_int_en_i (global_int_en_i),
`ifdef CLINT_TIMER_EN
    .mtimecmp_i      (mtimecmp_i),
`endif
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .raddr_o         (raddr_o),
    .data_o          (data_o),
    .hold_o          (hold_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  // Each cycle: advance past the edge, drive inputs, settle, then check.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_i = ECALL; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
      $display("FAIL reset_ctl got %b want 000", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
    tick();
    rst = 1'b0; inst_i = NOP; int_flag_i = '0; global_int_en_i = 1'b0;
    #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
      $display("FAIL reset_idle_ctl got %b want 000", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
    if ({waddr_o, raddr_o, data_o, int_addr_o} !== '0) begin
      $display("FAIL reset_buses got %h want 0", {waddr_o, raddr_o, data_o, int_addr_o}); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_ecall();
    tick();
    inst_i = ECALL; inst_addr_i = 64'h8000_0010; csr_mtvec_i = 64'h8000_1000;
    csr_mstatus_i = 64'h1808;
    #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b010) begin
      $display("FAIL ecall_t0 got %b want 010", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
    tick();
    inst_i = NOP; inst_addr_i = 64'h8000_0014;
    #1;
    if ({we_o, hold_o, int_assert_o, waddr_o, data_o} !== {3'b110, 64'h341, 64'h8000_0010}) begin
      $display("FAIL ecall_mepc got %b %h %h want 110 341 80000010",
               {we_o, hold_o, int_assert_o}, waddr_o, data_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o, waddr_o, data_o} !== {3'b110, 64'h300, 64'h1880}) begin
      $display("FAIL ecall_mstatus got %b %h %h want 110 300 1880",
               {we_o, hold_o, int_assert_o}, waddr_o, data_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o, waddr_o, data_o, int_addr_o} !==
        {3'b111, 64'h342, 64'd11, 64'h8000_1000}) begin
      $display("FAIL ecall_mcause got %b %h %h %h want 111 342 b 80001000",
               {we_o, hold_o, int_assert_o}, waddr_o, data_o, int_addr_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
      $display("FAIL ecall_done got %b want 000", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_mret();
    tick();
    inst_i = MRET; inst_addr_i = 64'h8000_1040; csr_mepc_i = 64'h8000_0014;
    csr_mstatus_i = 64'h80;
    #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b010) begin
      $display("FAIL mret_t0 got %b want 010", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
    tick();
    inst_i = NOP;
    #1;
    if ({we_o, hold_o, int_assert_o, waddr_o, data_o, int_addr_o} !==
        {3'b111, 64'h300, 64'h88, 64'h8000_0014}) begin
      $display("FAIL mret_write got %b %h %h %h want 111 300 88 80000014",
               {we_o, hold_o, int_assert_o}, waddr_o, data_o, int_addr_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
      $display("FAIL mret_done got %b want 000", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_irq_jump();
    tick();
    inst_i = NOP; inst_addr_i = 64'h8000_0100; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 64'h8000_0200; csr_mstatus_i = 64'h8;
    #1;
    if (hold_o !== 1'b1) begin
      $display("FAIL irq_t0_hold got %b want 1", hold_o); miscompares++;
    end
    vectors++;
    tick();
    int_flag_i = '0; jump_flag_i = 1'b0; global_int_en_i = 1'b0;
    #1;
    if ({we_o, waddr_o, data_o} !== {1'b1, 64'h341, 64'h8000_0200}) begin
      $display("FAIL irq_mepc got %b %h %h want 1 341 80000200", we_o, waddr_o, data_o);
      miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({waddr_o, data_o} !== {64'h300, 64'h80}) begin
      $display("FAIL irq_mstatus got %h %h want 300 80", waddr_o, data_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({int_assert_o, waddr_o, data_o, int_addr_o} !==
        {1'b1, 64'h342, 64'h8000_0000_0000_000B, 64'h8000_1000}) begin
      $display("FAIL irq_mcause got %b %h %h %h want 1 342 800000000000000b 80001000",
               int_assert_o, waddr_o, data_o, int_addr_o); miscompares++;
    end
    vectors++;
    tick(); #1;
  endtask

  task automatic test_irq_masked();
    for (int i = 0; i < 3; i++) begin
      tick();
      int_flag_i = 8'h01; global_int_en_i = 1'b0;
      #1;
      if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
        $display("FAIL irq_masked_%0d got %b want 000", i, {we_o, hold_o, int_assert_o});
        miscompares++;
      end
      vectors++;
    end
    int_flag_i = '0;
  endtask

  task automatic test_ecall_and_irq();
    tick();
    inst_i = ECALL; inst_addr_i = 64'h8000_0020; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 64'h8000_0300;
    #1;
    tick();
    inst_i = NOP; int_flag_i = '0; global_int_en_i = 1'b0; jump_flag_i = 1'b0;
    #1;
    if (data_o !== 64'h8000_0020) begin
      $display("FAIL both_mepc got %h want 80000020", data_o); miscompares++;
    end
    vectors++;
    tick(); tick(); #1;
    if ({int_assert_o, waddr_o, data_o} !== {1'b1, 64'h342, 64'd11}) begin
      $display("FAIL both_mcause got %b %h %h want 1 342 b", int_assert_o, waddr_o, data_o);
      miscompares++;
    end
    vectors++;
    tick(); #1;
  endtask

  task automatic test_back_to_back();
    tick();
    inst_i = EBREAK; inst_addr_i = 64'h8000_0030; csr_mstatus_i = 64'h1808;
    #1;
    tick(); #1;
    if ({we_o, waddr_o} !== {1'b1, 64'h341}) begin
      $display("FAIL b2b_mepc got %b %h want 1 341", we_o, waddr_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if (waddr_o !== 64'h300) begin
      $display("FAIL b2b_no_restart got %h want 300", waddr_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({waddr_o, data_o} !== {64'h342, 64'd3}) begin
      $display("FAIL b2b_mcause got %h %h want 342 3", waddr_o, data_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    // Back in IDLE with ebreak still presented: re-detected immediately
    if ({we_o, hold_o, int_assert_o} !== 3'b010) begin
      $display("FAIL b2b_redetect got %b want 010", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
    inst_i = NOP;
    #1;
    if (hold_o !== 1'b0) begin
      $display("FAIL b2b_drop got %b want 0", hold_o); miscompares++;
    end
    vectors++;
    tick(); #1;
    if ({we_o, hold_o, int_assert_o} !== 3'b000) begin
      $display("FAIL b2b_idle got %b want 000", {we_o, hold_o, int_assert_o}); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_rst_mid();
    tick();
    inst_i = ECALL; inst_addr_i = 64'h8000_0040;
    #1;
    tick();
    inst_i = NOP;
    #1;
    tick(); #1;
    if ({we_o, hold_o, waddr_o} !== {2'b11, 64'h300}) begin
      $display("FAIL rstmid_t2 got %b %h want 11 300", {we_o, hold_o}, waddr_o); miscompares++;
    end
    vectors++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 1'b0;
      #1;
      if ({we_o, hold_o, int_assert_o, waddr_o, data_o, int_addr_o} !== '0) begin
        $display("FAIL rstmid_after_%0d got %b %h %h %h want all 0", i,
                 {we_o, hold_o, int_assert_o}, waddr_o, data_o, int_addr_o); miscompares++;
      end
      vectors++;
    end
  endtask

`ifdef CLINT_TIMER_EN
  task automatic test_timer();
    int hit;
    hit = -1;
    tick();
    global_int_en_i = 1'b0; mtimecmp_i = 64'd20; rst = 1'b1;
    tick();
    rst = 1'b0; global_int_en_i = 1'b1;
    // Cycle index i carries mtime == i
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hit < 0 && hold_o === 1'b1) hit = i;
      if (hit >= 0) break;
      tick();
    end
    if (hit != 20) begin
      $display("FAIL timer_entry got cycle %0d want 20", hit); miscompares++;
    end
    vectors++;
    global_int_en_i = 1'b0; mtimecmp_i = '1;
    tick(); tick(); tick(); #1;
    if ({int_assert_o, data_o} !== {1'b1, 64'h8000_0000_0000_0007}) begin
      $display("FAIL timer_mcause got %b %h want 1 8000000000000007", int_assert_o, data_o);
      miscompares++;
    end
    vectors++;
    tick(); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
    int_flag_i = '0; csr_mtvec_i = 64'h8000_1000; csr_mepc_i = '0; csr_mstatus_i = '0;
    global_int_en_i = 1'b0;
`ifdef CLINT_TIMER_EN
    mtimecmp_i = '1;
`endif
    test_reset();
    test_ecall();
    test_mret();
    test_irq_jump();
    test_irq_masked();
    test_ecall_and_irq();
    test_back_to_back();
    test_rst_mid();
`ifdef CLINT_TIMER_EN
    test_timer();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
